otter_mem_arbiter: RTL
======================

Name: otter_mem_arbiter

Overview:
- Shares one single-ported unified memory between the OTTER core's instruction-fetch port and data port (von Neumann memory).
- Sits between `otter_mcu` and the memory. It serialises accesses, holds each request on a registered memory-side handshake until the memory acks, and returns the read data with a one-cycle ack pulse to the winning requester.
- A watchdog aborts hung accesses with an error response.

Parameters:
- TIMEOUT, 255, max cycles o_mem_req may stay high without i_mem_ack before abort; 0 disables the watchdog.
- ADDR_W, 32, address width on all ports.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_imem_req  in  1  fetch request; held stable until o_imem_ack
- i_imem_addr  in  ADDR_W  fetch address
- o_imem_r_data  out  32  fetch data, valid with o_imem_ack
- o_imem_ack  out  1  fetch complete (1-cycle pulse)
- o_imem_err  out  1  fetch aborted by watchdog, qualified by o_imem_ack
- i_dmem_re  in  1  data read request
- i_dmem_we  in  1  data write request
- i_dmem_sel  in  4  byte enables
- i_dmem_addr  in  ADDR_W  data address
- i_dmem_w_data  in  32  write data
- o_dmem_r_data  out  32  read data, valid with o_dmem_ack
- o_dmem_ack  out  1  data access complete (1-cycle pulse)
- o_dmem_err  out  1  data access aborted, qualified by o_dmem_ack
- o_mem_req  out  1  memory request, registered
- o_mem_we  out  1  write strobe, registered
- o_mem_sel  out  4  byte enables, registered (4'hF for fetch)
- o_mem_addr  out  ADDR_W  address, registered
- o_mem_w_data  out  32  write data, registered
- i_mem_ack  in  1  memory completes the current access this cycle
- i_mem_r_data  in  32  read data, valid with i_mem_ack

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous, active-high.
- Reset values: state=IDLE; o_mem_req, o_mem_we, o_*_ack, o_*_err all 0; o_mem_sel, o_mem_addr, o_mem_w_data all 0; o_*_r_data 0; watchdog count 0.
- States:
  - IDLE: samples requests.
  - IBUSY: fetch in flight.
  - DBUSY: data access in flight.
- Data request: dreq = i_dmem_re | i_dmem_we. If both re and we are high, the access is a write.
- Arbitration in IDLE: fixed priority, dmem over imem. On a grant, o_mem_* are registered from the winner and the state moves to I/DBUSY, so o_mem_req rises the next cycle. Fetch drives we=0, sel=4'hF.
- In BUSY:
  - o_mem_* stay frozen.
  - On i_mem_ack the owner's ack is driven combinationally in the same cycle: o_x_ack=1, o_x_r_data=i_mem_r_data (writes return i_mem_r_data too, ignored by the core).
  - On the next edge: o_mem_req→0, state→IDLE.
  - Non-owner ack and r_data stay 0.
- Minimum occupancy: 3 cycles per access when memory acks in the first req cycle (grant, req/ack, IDLE). The requester must change or drop its request in the cycle after ack.
- Watchdog:
  - Counts cycles with o_mem_req=1; clears on grant.
  - When the count reaches TIMEOUT with no ack, in that cycle o_x_ack=1, o_x_err=1, o_x_r_data=0; then state→IDLE and o_mem_req→0.
  - A coincident i_mem_ack in that cycle wins: normal completion, err=0.
  - A late i_mem_ack seen in IDLE is ignored.
- A request dropped by the requester while BUSY does not cancel the access; it completes and acks normally.
- Reset mid-access: next edge forces IDLE with o_mem_req=0. An i_mem_ack in the reset cycle produces no requester ack.
- o_*_ack never asserts for both requesters in the same cycle.
- o_mem_req is never high in IDLE.

Optional Feature:
- Macro: OTTER_ARB_ROUND_ROBIN_EN.
- Defined: one-bit last-grant register (reset = imem). On a simultaneous request in IDLE, the requester not granted last wins. Single requests are granted immediately.
- Undefined: fixed dmem-over-imem priority, and no last-grant flop exists.

Decomposition:
- Package otter_arb_pkg:
  - state enum (IDLE, IBUSY, DBUSY)
  - requester id enum (REQ_IMEM, REQ_DMEM)
  - constant FETCH_SEL = 4'hF
  - watchdog width function clog2(TIMEOUT+1)
- One sub-module, otter_arb_watchdog: load/clear, count-enable, expire output; tied off when TIMEOUT=0.

Test Plan:
- Fetch only: i_imem_req=1, addr 0x100, memory acks 2 cycles after req with 0x00000013 → o_mem_req high 2 cycles, o_mem_sel=4'hF, o_mem_we=0, o_imem_ack pulse with r_data 0x00000013, o_dmem_ack never high.
- Simultaneous requests: imem 0x200 and dmem write 0x8000 (sel 4'b0011, data 0xDEADBEEF), both in the same IDLE cycle, zero-wait memory → dmem granted first (o_mem_we=1, sel 0011), then imem served 3 cycles after the first grant. With OTTER_ARB_ROUND_ROBIN_EN and last grant=dmem, imem is granted first.
- re and we both high, addr 0x40 → o_mem_we=1, single access, one o_dmem_ack.
- Watchdog: TIMEOUT=4, memory never acks → o_dmem_ack=1, o_dmem_err=1, r_data=0 on the 4th req cycle. o_mem_req low the next cycle. A later i_mem_ack is ignored.
- Coincident ack at the timeout cycle with data 0x12345678 → err=0, r_data 0x12345678.
- Reset mid-access: i_rst pulsed during DBUSY with i_mem_ack=1 → no o_dmem_ack, next cycle state IDLE, o_mem_req=0, all outputs at reset values.

Source files
------------

// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types and constants for the OTTER unified-memory arbiter.
package otter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_e;

    localparam logic [3:0] FETCH_SEL = 4'hF;

    // Counter width able to hold 0..timeout; never narrower than one bit.
    function automatic int wd_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end else begin
            return $clog2(timeout + 1);
        end
    endfunction

endpackage

// File: rtl/otter_mem_arbiter_watchdog.sv
// Access watchdog: counts cycles with the memory request pending and flags
// expiry on the TIMEOUT-th one. TIMEOUT = 0 removes the counter entirely.
module otter_arb_watchdog
    import otter_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = wd_width(TIMEOUT);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // cnt_q holds completed pending cycles, so the current cycle is cnt_q+1
            assign expire_o = en_i && (cnt_q == LAST_CNT);

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i && !expire_o) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbiter sharing one single-ported memory between OTTER fetch and data ports.
// Define OTTER_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_imem_req,
    input  logic [ADDR_W-1:0] i_imem_addr,
    output logic [31:0]       o_imem_r_data,
    output logic              o_imem_ack,
    output logic              o_imem_err,
    input  logic              i_dmem_re,
    input  logic              i_dmem_we,
    input  logic [3:0]        i_dmem_sel,
    input  logic [ADDR_W-1:0] i_dmem_addr,
    input  logic [31:0]       i_dmem_w_data,
    output logic [31:0]       o_dmem_r_data,
    output logic              o_dmem_ack,
    output logic              o_dmem_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_sel,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_w_data,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_r_data
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_w_data_q, mem_w_data_d;

    logic    dreq_s;
    logic    grant_s;
    logic    done_s;
    logic    wd_expire_s;
    req_id_e winner_s;

    assign dreq_s  = i_dmem_re | i_dmem_we;
    assign grant_s = (state_q == IDLE) && (dreq_s || i_imem_req);
    assign done_s  = (state_q != IDLE) && (i_mem_ack || wd_expire_s);

`ifdef OTTER_ARB_ROUND_ROBIN_EN
    req_id_e last_q;

    always_comb begin
        if (dreq_s && i_imem_req) begin
            winner_s = (last_q == REQ_DMEM) ? REQ_IMEM : REQ_DMEM;
        end else if (dreq_s) begin
            winner_s = REQ_DMEM;
        end else begin
            winner_s = REQ_IMEM;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= REQ_IMEM;
        end else if (grant_s) begin
            last_q <= winner_s;
        end else begin
            last_q <= last_q;
        end
    end
`else
    assign winner_s = dreq_s ? REQ_DMEM : REQ_IMEM;
`endif

    otter_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clr_i    (grant_s),
        .en_i     (mem_req_q),
        .expire_o (wd_expire_s)
    );

    // Memory-side fields are loaded only on a grant and frozen until completion.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_sel_d    = mem_sel_q;
        mem_addr_d   = mem_addr_q;
        mem_w_data_d = mem_w_data_q;
        case (state_q)
            IDLE: begin
                if (grant_s && (winner_s == REQ_DMEM)) begin
                    state_d      = DBUSY;
                    mem_req_d    = 1'b1;
                    mem_we_d     = i_dmem_we;
                    mem_sel_d    = i_dmem_sel;
                    mem_addr_d   = i_dmem_addr;
                    mem_w_data_d = i_dmem_w_data;
                end else if (grant_s) begin
                    state_d      = IBUSY;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_sel_d    = FETCH_SEL;
                    mem_addr_d   = i_imem_addr;
                    mem_w_data_d = 32'h0000_0000;
                end else begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            IBUSY, DBUSY: begin
                if (done_s) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d   = state_q;
                    mem_req_d = mem_req_q;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Requester responses are combinational so the ack lands in the memory-ack cycle.
    always_comb begin
        o_imem_ack    = 1'b0;
        o_imem_err    = 1'b0;
        o_imem_r_data = 32'h0000_0000;
        o_dmem_ack    = 1'b0;
        o_dmem_err    = 1'b0;
        o_dmem_r_data = 32'h0000_0000;
        if (done_s && !i_rst) begin
            if (state_q == IBUSY) begin
                o_imem_ack    = 1'b1;
                o_imem_err    = !i_mem_ack;
                o_imem_r_data = i_mem_ack ? i_mem_r_data : 32'h0000_0000;
            end else begin
                o_dmem_ack    = 1'b1;
                o_dmem_err    = !i_mem_ack;
                o_dmem_r_data = i_mem_ack ? i_mem_r_data : 32'h0000_0000;
            end
        end else begin
            o_imem_ack = 1'b0;
            o_dmem_ack = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_sel_q    <= 4'h0;
            mem_addr_q   <= '0;
            mem_w_data_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_sel_q    <= mem_sel_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
        end
    end

    assign o_mem_req    = mem_req_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_sel    = mem_sel_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_w_data = mem_w_data_q;

endmodule
